// File: rtl/fp32_pkg.sv
// Shared types and constants for the single-precision adder datapath.
// The unpacked operand layout is common to the add/align and normalise/round stages.
package fp32_pkg;

  localparam int FP_EXP_W   = 10;
  localparam int FP_MAN_W   = 28;
  localparam int FP_FRAC_W  = 23;
  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MIN = -126;
  localparam logic [7:0] FP_EXP_INF = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    NORM,
    DENORM,
    ROUND,
    PACK,
    OUT
  } norm_state_e;

  typedef struct packed {
    logic                       sign;
    logic signed [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0]        man;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a hidden+fraction+G/R/S mantissa.
// Returns the rounded 24-bit significand and the carry-out of the increment.
module fp_round_rne (
  input  logic [26:0] i_man,
  output logic [23:0] o_man,
  output logic        o_carry
);

  function automatic logic [24:0] round_rne(input logic [26:0] man);
    logic inc;
    inc = man[2] && (man[1] || man[0] || man[3]);
    return {1'b0, man[26:3]} + {24'h0, inc};
  endfunction

  logic [24:0] w_sum;

  assign w_sum            = round_rne(i_man);
  assign {o_carry, o_man} = w_sum;

endmodule

// File: rtl/fp32_normalize_round.sv
// Post-add stage: normalises, denormalises, rounds (RNE) and packs a binary32 result.
// Multi-cycle FSM with one operation in flight and a bypass for pre-resolved specials.
module fp32_normalize_round
  import fp32_pkg::*;
#(
  parameter int EXP_W   = FP_EXP_W,
  parameter int BIAS    = FP_BIAS,
  parameter int EXP_MIN = FP_EXP_MIN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [27:0]             in_man,
  input  logic                    in_special,
  input  logic [31:0]             in_special_val,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [31:0]             c,
  output logic                    c_valid,
  input  logic                    c_ready
);

  localparam logic signed [EXP_W-1:0] EMIN  = EXP_W'(EXP_MIN);
  localparam logic signed [EXP_W-1:0] EMAX  = EXP_W'(BIAS);
  localparam logic signed [EXP_W-1:0] EBIAS = EXP_W'(BIAS);
  localparam logic signed [EXP_W-1:0] EONE  = EXP_W'(1);

  norm_state_e             r_state;
  logic                    r_sign;
  logic signed [EXP_W-1:0] r_exp;
  logic [27:0]             r_man;
  logic [31:0]             r_c;
  logic                    r_c_valid;

  logic                    w_accept;
  logic signed [EXP_W-1:0] w_exp_inc;
  logic signed [EXP_W-1:0] w_exp_dec;
  logic signed [EXP_W-1:0] w_biased;
  logic [27:0]             w_man_rsh;
  logic [23:0]             w_rnd_man;
  logic                    w_rnd_carry;
  logic [31:0]             w_pack;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_exp_inc = r_exp + EONE;
  assign w_exp_dec = r_exp - EONE;
  assign w_biased  = r_exp + EBIAS;
  // Right shift that folds the two dropped-out bits into sticky.
  assign w_man_rsh = {1'b0, r_man[27:2], r_man[1] | r_man[0]};

  assign c       = r_c;
  assign c_valid = r_c_valid;

  fp_round_rne u_round (
    .i_man   (r_man[26:0]),
    .o_man   (w_rnd_man),
    .o_carry (w_rnd_carry)
  );

  always_comb begin
    w_pack = {r_sign, w_biased[7:0], r_man[25:3]};
    if (r_exp > EMAX) begin
      w_pack = {r_sign, FP_EXP_INF, 23'h0};
    end else if (!r_man[26]) begin
      w_pack = {r_sign, 8'h00, r_man[25:3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_man     <= '0;
      r_c       <= '0;
      r_c_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign <= in_sign;
            r_exp  <= in_exp;
            r_man  <= in_man;
            if (in_special) begin
              r_c       <= in_special_val;
              r_c_valid <= 1'b1;
              r_state   <= OUT;
            end else begin
              r_state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (r_man[27]) begin
            r_man <= w_man_rsh;
            r_exp <= w_exp_inc;
          end
          r_state <= NORM;
        end
        NORM: begin
          // Shifting stops at EXP_MIN so a zero mantissa terminates as a denormal zero.
          if (!r_man[26] && (r_exp > EMIN)) begin
            r_man <= {r_man[26:0], 1'b0};
            r_exp <= w_exp_dec;
          end else if (r_exp < EMIN) begin
            r_state <= DENORM;
          end else begin
            r_state <= ROUND;
          end
        end
        DENORM: begin
          r_man <= w_man_rsh;
          r_exp <= w_exp_inc;
          if (w_exp_inc == EMIN) begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          if (w_rnd_carry) begin
            r_man <= {1'b0, 1'b1, w_rnd_man, 2'b00};
            r_exp <= w_exp_inc;
          end else begin
            r_man <= {1'b0, w_rnd_man, 3'b000};
          end
          r_state <= PACK;
        end
        PACK: begin
          r_c       <= w_pack;
          r_c_valid <= 1'b1;
          r_state   <= OUT;
        end
        OUT: begin
          if (c_ready) begin
            r_c_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_normalize_round.sv
// Directed, table-driven bench for fp32_normalize_round: value, latency, handshake,
// backpressure and mid-operation reset.
module tb_fp32_normalize_round;

  logic              clk;
  logic              rst;
  logic              in_sign;
  logic signed [9:0] in_exp;
  logic [27:0]       in_man;
  logic              in_special;
  logic [31:0]       in_special_val;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       c;
  logic              c_valid;
  logic              c_ready;

  int checks;
  int fails;

  typedef struct {
    string             name;
    logic              sign;
    logic signed [9:0] exp;
    logic [27:0]       man;
    logic              special;
    logic [31:0]       sval;
    logic [31:0]       exp_c;
    int                exp_lat;
  } vec_t;

  vec_t vecs[$];

  fp32_normalize_round dut (
    .clk            (clk),
    .rst            (rst),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_man         (in_man),
    .in_special     (in_special),
    .in_special_val (in_special_val),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .c              (c),
    .c_valid        (c_valid),
    .c_ready        (c_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at a negedge after the result has been consumed.
  task automatic run_vec(input vec_t v, input int hold);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, "_ready_before"}, {31'b0, in_ready}, 32'd1);
    in_sign        = v.sign;
    in_exp         = v.exp;
    in_man         = v.man;
    in_special     = v.special;
    in_special_val = v.sval;
    in_valid       = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_special = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!c_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, "_c"}, c, v.exp_c);
    chk({v.name, "_lat"}, 32'(lat), 32'(v.exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({v.name, "_hold_c"}, c, v.exp_c);
      chk({v.name, "_hold_vld"}, {31'b0, c_valid}, 32'd1);
      chk({v.name, "_hold_rdy"}, {31'b0, in_ready}, 32'd0);
    end
    c_ready = 1'b1;
    @(posedge clk);
    #1;
    c_ready = 1'b0;
    @(negedge clk);
    chk({v.name, "_vld_drop"}, {31'b0, c_valid}, 32'd0);
    chk({v.name, "_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst = 1'b1;
    in_sign = 1'b0;
    in_exp = '0;
    in_man = '0;
    in_special = 1'b0;
    in_special_val = '0;
    in_valid = 1'b0;
    c_ready = 1'b0;

    vecs.push_back('{"one",        1'b0,  10'sd0,   28'h4000000, 1'b0, 32'h0, 32'h3F800000, 5});
    vecs.push_back('{"carry",      1'b0,  10'sd0,   28'h8000000, 1'b0, 32'h0, 32'h40000000, 5});
    vecs.push_back('{"cancel",     1'b0,  10'sd0,   28'h0100000, 1'b0, 32'h0, 32'h3C800000, 11});
    vecs.push_back('{"neg_zero",   1'b1,  10'sd0,   28'h0000000, 1'b0, 32'h0, 32'h80000000, 131});
    vecs.push_back('{"rne_even",   1'b0,  10'sd0,   28'h4000004, 1'b0, 32'h0, 32'h3F800000, 5});
    vecs.push_back('{"rne_odd",    1'b0,  10'sd0,   28'h400000C, 1'b0, 32'h0, 32'h3F800002, 5});
    vecs.push_back('{"overflow",   1'b0,  10'sd127, 28'h8000000, 1'b0, 32'h0, 32'h7F800000, 5});
    vecs.push_back('{"rollover",   1'b0,  10'sd0,   28'h7FFFFFC, 1'b0, 32'h0, 32'h40000000, 5});
    vecs.push_back('{"neg_twelve", 1'b1,  10'sd3,   28'h6000000, 1'b0, 32'h0, 32'hC1400000, 5});
    vecs.push_back('{"denorm1",    1'b0, -10'sd127, 28'h4000000, 1'b0, 32'h0, 32'h00400000, 6});
    vecs.push_back('{"denorm_min", 1'b0, -10'sd149, 28'h4000000, 1'b0, 32'h0, 32'h00000001, 28});
    vecs.push_back('{"denorm_tie", 1'b1, -10'sd150, 28'h4000000, 1'b0, 32'h0, 32'h80000000, 29});
    vecs.push_back('{"bypass_nan", 1'b0,  10'sd0,   28'h0000000, 1'b1, 32'h7FC00000, 32'h7FC00000, 1});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_c", c, 32'h0);
    chk("rst_c_valid", {31'b0, c_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], 0);
    end

    // Backpressure on both the bypass and normal paths.
    run_vec(vecs[12], 10);
    run_vec(vecs[2], 10);

    // Reset while the zero operand is still shifting in NORM.
    in_sign  = 1'b1;
    in_exp   = 10'sd0;
    in_man   = 28'h0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_c_valid", {31'b0, c_valid}, 32'd0);
    chk("mid_rst_in_ready_up", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_c", c, 32'h0);
    repeat (140) @(negedge clk);
    chk("mid_rst_discarded", {31'b0, c_valid}, 32'd0);
    run_vec(vecs[5], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
